// File: rtl/gb_pkg.sv
// Shared Game Boy core package: OAM DMA constants and state type.
package gb_pkg;

    // Number of bytes copied into OAM by one DMA transfer.
    localparam int GB_OAM_DMA_LEN = 160;

    // Low byte of the FF46 DMA register address in the io map.
    localparam logic [7:0] GB_IO_DMA_ADR = 8'h46;

    // Index of the last OAM byte of a transfer.
    localparam logic [7:0] GB_OAM_DMA_LAST = 8'(GB_OAM_DMA_LEN - 1);

    // OAM DMA controller state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } dma_state_t;

endpackage

// File: rtl/gb_oam_dma.sv
// OAM DMA controller (FF46). A CPU write to FF46 starts a copy of 160 bytes
// from {page, 8'h00} into OAM, one byte per M-cycle (4 gbclk clocks).
// Optional feature macro: GB_OAM_DMA_ECHO_FOLD_EN folds source pages E0..FF
// onto the work RAM echo C0..DF; the register read-back is never folded.
//
// Bus ownership handshake: active is high from the clock after the FF46 write
// until the last OAM write completes; while active the top level hands the
// external and video buses to dma_adr/dma_rd and oam_adr/oam_dout/oam_wr.
// dma_rd is a level request held for phases 0-2 of each byte, and the bus must
// return the byte on dma_din by the posedge that ends phase 2.
module gb_oam_dma
    import gb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        write,
    input  logic        read,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic [7:0]  dma_din,
    output logic [15:0] dma_adr,
    output logic        dma_rd,
    output logic [7:0]  oam_adr,
    output logic [7:0]  oam_dout,
    output logic        oam_wr,
    output logic        active
);

    // Internal state, kept under plain names so checkers can bind to them.
    dma_state_t state;
    logic [1:0] phase;
    logic [7:0] idx;
    logic [7:0] page;
    logic [7:0] src_page;

    // Reads of FF46 have no side effect; the strobe is deliberately unused.
    logic unused_read;
    assign unused_read = read;

`ifdef GB_OAM_DMA_ECHO_FOLD_EN
    // Echo RAM pages E0..FF read the work RAM they mirror.
    assign src_page = (page >= 8'hE0) ? (page - 8'h20) : page;
`else
    assign src_page = page;
`endif

    // Outputs are pure decodes of registered state; no input reaches them.
    assign active   = (state != IDLE);
    assign dma_rd   = (state == XFER) && (phase != 2'd3);
    assign oam_wr   = (state == XFER) && (phase == 2'd3);
    assign oam_adr  = (state == XFER) ? idx : 8'h00;
    assign dma_adr  = (state == IDLE) ? 16'h0000 : {src_page, idx};
    assign dout     = page;

    // Transfer sequencer: a FF46 write restarts from any state, otherwise
    // step phase/idx through START and XFER and capture each bus byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            page     <= 8'h00;
            phase    <= 2'd0;
            idx      <= 8'h00;
            oam_dout <= 8'h00;
        end else if (sel && write) begin
            page  <= din;
            phase <= 2'd0;
            idx   <= 8'h00;
            state <= START;
        end else begin
            case (state)
                IDLE: begin
                    phase <= 2'd0;
                end
                START: begin
                    phase <= phase + 2'd1;
                    if (phase == 2'd3) begin
                        state <= XFER;
                    end
                end
                XFER: begin
                    phase <= phase + 2'd1;
                    // Bus data is valid at the end of the third read clock.
                    if (phase == 2'd2) begin
                        oam_dout <= dma_din;
                    end
                    if (phase == 2'd3) begin
                        if (idx == GB_OAM_DMA_LAST) begin
                            state <= IDLE;
                            idx   <= 8'h00;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    phase <= 2'd0;
                end
            endcase
        end
    end

endmodule
